// File: rtl/vgroup_pkg.sv
// Shared definitions for LMUL register grouping: LMUL encodings, the
// encoding-to-count decode (also used by the grouping selector) and the
// collector FSM states.
package vgroup_pkg;

  localparam logic [2:0] LMUL_1 = 3'b000;
  localparam logic [2:0] LMUL_2 = 3'b001;
  localparam logic [2:0] LMUL_4 = 3'b010;
  localparam logic [2:0] LMUL_8 = 3'b011;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // Number of registers in a group; 0 flags a reserved (1xx) encoding.
  function automatic logic [3:0] lmul_decode(input logic [2:0] enc);
    case (enc)
      LMUL_1:  return 4'd1;
      LMUL_2:  return 4'd2;
      LMUL_4:  return 4'd4;
      LMUL_8:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vgroup_scoreboard.sv
// Busy mask over the vector registers: a group start marks a contiguous
// range busy, each completed write clears one bit, flush clears all.
module vgroup_scoreboard #(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [4:0]      set_base,
  input  logic [3:0]      set_n,
  input  logic            clr_en,
  input  logic [4:0]      clr_idx,
  input  logic            flush,
  output logic [NREG-1:0] mask
);

  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Expand (base, n) into a range of bits and the clear index into one bit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      if (set_en && (i >= int'(set_base)) && (i < int'(set_base) + int'(set_n)))
        set_mask[i] = 1'b1;
      if (clr_en && (i == int'(clr_idx)))
        clr_mask[i] = 1'b1;
    end
  end

  // Flush wins; otherwise set and clear are applied together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     mask <= '0;
    else if (flush) mask <= '0;
    else            mask <= (mask | set_mask) & ~clr_mask;
  end

endmodule

// File: rtl/vgroup_wb_collector.sv
// Write-back collector for LMUL register groups. Accepts a group header,
// checks that micro-op results arrive in order (cnt 0..N-1, rdest = base+cnt)
// and writes each to the register file one cycle after acceptance.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. grp_ready = IDLE, uop_ready = COLLECT; ready never depends on
// valid. A mismatching micro-op is still consumed (and dropped) while ready.
module vgroup_wb_collector
  import vgroup_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              grp_start_valid,
  output logic              grp_ready,
  input  logic [4:0]        grp_rdest,
  input  logic [2:0]        grp_lmul,
  input  logic              uop_valid,
  output logic              uop_ready,
  input  logic [2:0]        uop_cnt,
  input  logic [4:0]        uop_rdest,
  input  logic [DATA_W-1:0] uop_data,
  input  logic              flush,
  output logic              vrf_we,
  output logic [4:0]        vrf_waddr,
  output logic [DATA_W-1:0] vrf_wdata,
  output logic [NREG-1:0]   busy_mask,
  output logic              grp_done,
  output logic              err_seq,
  input  logic              err_clr
);

  state_t     state_q, state_d;
  logic [4:0] base_q, base_d;
  logic [3:0] n_q, n_d;
  logic [2:0] exp_q, exp_d;

  logic [3:0] start_n;
  logic       start_ok;
  logic       wr_d, done_d, err_set;
  logic       sb_set, sb_clr;
  logic       uop_match;

  assign grp_ready = (state_q == ST_IDLE);
  assign uop_ready = (state_q == ST_COLLECT);

  // Next-state, acceptance and error detection; flush overrides all of it.
  always_comb begin
    start_n   = lmul_decode(grp_lmul);
    start_ok  = (start_n != 4'd0) &&
                ((grp_rdest & ({1'b0, start_n} - 5'd1)) == 5'd0);
    uop_match = (uop_cnt == exp_q) && (uop_rdest == base_q + {2'b00, exp_q});
    state_d   = state_q;
    base_d    = base_q;
    n_d       = n_q;
    exp_d     = exp_q;
    wr_d      = 1'b0;
    done_d    = 1'b0;
    err_set   = 1'b0;
    sb_set    = 1'b0;
    sb_clr    = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      exp_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grp_start_valid) begin
            if (start_ok) begin
              base_d  = grp_rdest;
              n_d     = start_n;
              exp_d   = 3'd0;
              sb_set  = 1'b1;
              state_d = ST_COLLECT;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (uop_valid) begin
            if (uop_match) begin
              wr_d   = 1'b1;
              sb_clr = 1'b1;
              exp_d  = exp_q + 3'd1;
              if ({1'b0, exp_q} == n_q - 4'd1) begin
                done_d  = 1'b1;
                exp_d   = 3'd0;
                state_d = ST_IDLE;
              end
            end else begin
              err_set = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state and group context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= 5'd0;
      n_q     <= 4'd0;
      exp_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      n_q     <= n_d;
      exp_q   <= exp_d;
    end
  end

  // Registered register-file write; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vrf_we    <= 1'b0;
      vrf_waddr <= 5'd0;
      vrf_wdata <= '0;
      grp_done  <= 1'b0;
    end else begin
      vrf_we   <= wr_d;
      grp_done <= done_d;
      if (wr_d) begin
        vrf_waddr <= uop_rdest;
        vrf_wdata <= uop_data;
      end
    end
  end

  // Sticky error flag; a new error in the clearing cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_seq <= 1'b0;
    else if (err_set) err_seq <= 1'b1;
    else if (err_clr) err_seq <= 1'b0;
  end

  vgroup_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (sb_set),
    .set_base (grp_rdest),
    .set_n    (start_n),
    .clr_en   (sb_clr),
    .clr_idx  (uop_rdest),
    .flush    (flush),
    .mask     (busy_mask)
  );

endmodule

// File: tb/tb_vgroup_wb_collector.sv
// Directed bench for vgroup_wb_collector: stimulus pushes expected writes
// into a queue, a negedge monitor pops and compares every vrf write.
module tb_vgroup_wb_collector;

  localparam int DATA_W = 128;
  localparam int NREG   = 32;
  localparam int IW     = 1 + 5 + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              grp_start_valid;
  logic              grp_ready;
  logic [4:0]        grp_rdest;
  logic [2:0]        grp_lmul;
  logic              uop_valid;
  logic              uop_ready;
  logic [2:0]        uop_cnt;
  logic [4:0]        uop_rdest;
  logic [DATA_W-1:0] uop_data;
  logic              flush;
  logic              vrf_we;
  logic [4:0]        vrf_waddr;
  logic [DATA_W-1:0] vrf_wdata;
  logic [NREG-1:0]   busy_mask;
  logic              grp_done;
  logic              err_seq;
  logic              err_clr;

  logic [IW-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  vgroup_wb_collector #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .grp_start_valid (grp_start_valid),
    .grp_ready       (grp_ready),
    .grp_rdest       (grp_rdest),
    .grp_lmul        (grp_lmul),
    .uop_valid       (uop_valid),
    .uop_ready       (uop_ready),
    .uop_cnt         (uop_cnt),
    .uop_rdest       (uop_rdest),
    .uop_data        (uop_data),
    .flush           (flush),
    .vrf_we          (vrf_we),
    .vrf_waddr       (vrf_waddr),
    .vrf_wdata       (vrf_wdata),
    .busy_mask       (busy_mask),
    .grp_done        (grp_done),
    .err_seq         (err_seq),
    .err_clr         (err_clr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [IW-1:0] got,
                       input logic [IW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input logic [4:0] r);
    return {96'hFACE_CAFE_0123_4567_89AB_CDEF, 27'h5A5A5A5, r};
  endfunction

  // Scoreboard monitor: every write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vrf_we) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_write: got waddr %0d done %0b expected no write",
                   vrf_waddr, grp_done);
        end else begin
          check("vrf_write", {grp_done, vrf_waddr, vrf_wdata}, exp_q.pop_front());
        end
      end else if (grp_done) begin
        n_total++;
        $display("FAIL lone_grp_done: got grp_done 1 expected 0 without vrf_we");
      end
    end
  end

  // Driver tasks; each returns 1 time unit after the edge that sampled inputs.
  task automatic start_grp(input logic [4:0] rd, input logic [2:0] lm,
                           input logic fl);
    grp_start_valid = 1'b1;
    grp_rdest       = rd;
    grp_lmul        = lm;
    flush           = fl;
    @(posedge clk); #1;
    grp_start_valid = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic send_uop(input logic [2:0] cnt, input logic [4:0] rd,
                          input logic expect_wr, input logic last,
                          input logic fl);
    uop_valid = 1'b1;
    uop_cnt   = cnt;
    uop_rdest = rd;
    uop_data  = mk_data(rd);
    flush     = fl;
    if (expect_wr) exp_q.push_back({last, rd, mk_data(rd)});
    @(posedge clk); #1;
    uop_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; grp_start_valid = 1'b0; grp_rdest = '0; grp_lmul = '0;
    uop_valid = 1'b0; uop_cnt = '0; uop_rdest = '0; uop_data = '0;
    flush = 1'b0; err_clr = 1'b0;

    #12;
    check("rst_grp_ready", IW'(grp_ready), IW'(1));
    check("rst_uop_ready", IW'(uop_ready), IW'(0));
    check("rst_busy",      IW'(busy_mask), IW'(0));
    check("rst_outs",      IW'({vrf_we, grp_done, err_seq, vrf_waddr}), IW'(0));
    rst_n = 1'b1;
    idle(1);

    // LMUL=1, base 5
    start_grp(5'd5, 3'b000, 1'b0);
    check("l1_busy", IW'(busy_mask), IW'(32'h0000_0020));
    check("l1_uop_ready", IW'(uop_ready), IW'(1));
    send_uop(3'd0, 5'd5, 1'b1, 1'b1, 1'b0);
    check("l1_busy_after", IW'(busy_mask), IW'(0));
    check("l1_grp_ready", IW'(grp_ready), IW'(1));
    idle(1);

    // LMUL=4, base 8, back-to-back micro-ops
    start_grp(5'd8, 3'b010, 1'b0);
    check("l4_busy", IW'(busy_mask), IW'(32'h0000_0F00));
    for (int i = 0; i < 4; i++) begin
      send_uop(3'(i), 5'(8 + i), 1'b1, (i == 3), 1'b0);
      check("l4_busy_step", IW'(busy_mask), IW'(32'h0000_0F00 & ~((32'h100 << (i + 1)) - 32'h100)));
    end
    check("l4_grp_ready_final", IW'({grp_ready, vrf_we, grp_done}), IW'(3'b111));
    idle(1);

    // LMUL=2, base 4, out-of-order first micro-op
    start_grp(5'd4, 3'b001, 1'b0);
    send_uop(3'd1, 5'd5, 1'b0, 1'b0, 1'b0);
    check("seq_err", IW'({err_seq, vrf_we}), IW'(2'b10));
    check("seq_busy", IW'(busy_mask), IW'(32'h0000_0030));
    send_uop(3'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    send_uop(3'd1, 5'd5, 1'b1, 1'b1, 1'b0);
    check("seq_busy_after", IW'(busy_mask), IW'(0));
    pulse_err_clr();
    check("seq_err_clr", IW'(err_seq), IW'(0));

    // Misaligned base and reserved LMUL
    start_grp(5'd3, 3'b001, 1'b0);
    check("misalign", IW'({err_seq, grp_ready, uop_ready}), IW'(3'b110));
    check("misalign_busy", IW'(busy_mask), IW'(0));
    pulse_err_clr();
    start_grp(5'd0, 3'b100, 1'b0);
    check("bad_lmul", IW'({err_seq, grp_ready, uop_ready}), IW'(3'b110));
    check("bad_lmul_busy", IW'(busy_mask), IW'(0));
    pulse_err_clr();

    // Flush together with a start: group not accepted
    start_grp(5'd8, 3'b000, 1'b1);
    check("flush_start", IW'({grp_ready, busy_mask}), IW'({1'b1, 32'h0}));

    // LMUL=8, base 16, flush on the third accepted micro-op
    start_grp(5'd16, 3'b011, 1'b0);
    check("l8_busy", IW'(busy_mask), IW'(32'h00FF_0000));
    send_uop(3'd0, 5'd16, 1'b1, 1'b0, 1'b0);
    send_uop(3'd1, 5'd17, 1'b1, 1'b0, 1'b0);
    send_uop(3'd2, 5'd18, 1'b0, 1'b0, 1'b1);
    check("flush_state", IW'({grp_ready, vrf_we, grp_done, busy_mask}),
          IW'({3'b100, 32'h0}));
    idle(3);
    check("flush_drain", IW'(exp_q.size()), IW'(0));

    // Reset during a group with a write pending
    start_grp(5'd0, 3'b001, 1'b0);
    uop_valid = 1'b1; uop_cnt = 3'd0; uop_rdest = 5'd0; uop_data = mk_data(5'd0);
    @(posedge clk); #1;
    uop_cnt = 3'd1; uop_rdest = 5'd1; uop_data = mk_data(5'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", IW'({vrf_we, grp_done, err_seq, vrf_waddr, busy_mask}), IW'(0));
    check("rst_mid_wdata", IW'(vrf_wdata), IW'(0));
    check("rst_mid_ready", IW'({grp_ready, uop_ready}), IW'(2'b10));
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    uop_valid = 1'b0;
    check("rst_no_write", IW'({vrf_we, busy_mask}), IW'(0));
    start_grp(5'd2, 3'b000, 1'b0);
    check("post_rst_busy", IW'(busy_mask), IW'(32'h0000_0004));
    send_uop(3'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("final_drain", IW'(exp_q.size()), IW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vgroup_wb_collector.md
Name: vgroup_wb_collector

Overview:
- Write-back end of LMUL register grouping. The grouping selector expands one vector instruction into LMUL micro-ops (cnt = 0..LMUL-1, register = base + cnt).
- This block receives the resulting per-register ALU results, checks their sequence and writes them to the vector register file one register per cycle.
- It keeps a busy scoreboard over the group's registers for hazard checks and pulses group completion.
- Sits between the vector ALU output and the vregfile write port.

Parameters:
- DATA_W, 128, width of one vector register / micro-op result
- NREG, 32, number of vector registers (scoreboard width)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- grp_start_valid  in  1  issue side announces a new group
- grp_ready  out  1  collector can accept a new group
- grp_rdest  in  5  group base destination register
- grp_lmul  in  3  encoded LMUL: 000=1, 001=2, 010=4, 011=8; 1xx is invalid
- uop_valid  in  1  micro-op result valid
- uop_ready  out  1  collector accepts micro-op
- uop_cnt  in  3  micro-op index within the group
- uop_rdest  in  5  micro-op destination register
- uop_data  in  DATA_W  micro-op result
- flush  in  1  abort current group (synchronous)
- vrf_we  out  1  register file write enable
- vrf_waddr  out  5  register file write address
- vrf_wdata  out  DATA_W  register file write data
- busy_mask  out  NREG  one bit per register with a pending write
- grp_done  out  1  one-cycle pulse on the last write of a group
- err_seq  out  1  sticky protocol error
- err_clr  in  1  clears err_seq

Behaviour:
- Reset (async, rst_n=0): state IDLE; vrf_we=0, vrf_waddr=0, vrf_wdata=0, busy_mask=0, grp_done=0, err_seq=0, expected=0, N=0. Reset mid-group discards the group; no write occurs after reset.
- FSM states: IDLE and COLLECT. grp_ready = (state==IDLE). uop_ready = (state==COLLECT).
- IDLE, on grp_start_valid:
  - Decode grp_lmul into N (1/2/4/8).
  - Invalid LMUL (1xx), or base not aligned (grp_rdest mod N != 0): set err_seq, stay IDLE, busy_mask unchanged.
  - Otherwise latch base=grp_rdest, set busy_mask bits base..base+N-1, expected=0, go COLLECT.
  - Alignment guarantees base+N-1 <= 31, so no wrap-around.
- COLLECT, on uop_valid:
  - Match when uop_cnt==expected and uop_rdest==base+expected.
  - On match, register the write with one-cycle latency: next cycle vrf_we=1, vrf_waddr=uop_rdest, vrf_wdata=uop_data.
  - busy bit uop_rdest clears in the same cycle vrf_we is high. Increment expected.
  - If the matched micro-op had expected==N-1: grp_done=1 together with that final vrf_we, and state returns to IDLE on the acceptance edge. grp_ready is therefore high during the final write cycle; a group accepted then takes effect on the following edge.
  - On mismatch: set err_seq, drop the micro-op (no write), expected unchanged.
- vrf_we and grp_done are low in every cycle not described above.
- flush (priority over everything except reset):
  - Go IDLE, clear busy_mask, clear expected.
  - Suppress a write registered in the same cycle, i.e. no vrf_we on the next cycle.
  - flush together with grp_start_valid: the group is not accepted.
- err_clr clears err_seq. If an error is detected in the same cycle, the set wins.
- grp_start_valid while in COLLECT is ignored; the issuer holds it until grp_ready.

Decomposition:
- Shared package vgroup_pkg:
  - LMUL encodings: LMUL_1=3'b000, LMUL_2=3'b001, LMUL_4=3'b010, LMUL_8=3'b011.
  - Function lmul_decode(enc) returning the count, with 0 for invalid.
  - FSM state constants ST_IDLE and ST_COLLECT.
  - This decode is shared with the grouping selector.
- One natural sub-module, vgroup_scoreboard: NREG-bit mask with a range-set input (base, N) and a single-bit clear input, flush-clear, asynchronous reset.

Test Plan:
- LMUL=1 (grp_rdest=5, lmul=000), one micro-op (cnt=0, rdest=5, data=A) -> busy_mask=0x20 after start; next cycle vrf_we=1, waddr=5, wdata=A, grp_done=1; busy_mask=0 after.
- LMUL=4, base=8, micro-ops cnt 0..3 back-to-back with rdest 8..11 -> four consecutive writes to 8,9,10,11; busy_mask 0xF00 clears bit by bit; grp_done only with the write to 11; grp_ready high in that same cycle.
- LMUL=2, base=4, micro-op cnt=1 sent first -> err_seq=1, no write, busy_mask=0x30 unchanged; then cnt=0 and cnt=1 complete normally; err_clr then drops err_seq to 0.
- Misaligned start (base=3, LMUL=2) and invalid lmul=100 -> err_seq=1, grp_ready stays 1, busy_mask=0, no state change.
- LMUL=8, base=16, flush after 3 accepted micro-ops (asserted in the cycle the 3rd is accepted) -> only 2 writes (16,17), busy_mask=0, state IDLE, no grp_done.
- rst_n low while in COLLECT with a write pending -> all outputs 0 immediately, no vrf_we after release, new group accepted normally.
